// File: rtl/id_sb_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_sb_queue_pkg
//  Description : Shared constants for the decode-to-scoreboard queue.
//                This includes the record width, the default depth and the
//                bit positions of the inst_info fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_sb_queue_pkg;

    // Width of one decoded-instruction record handed to the scoreboard
    localparam int ID_TO_SB_WD       = 137;

    // Default queue depth (power of two, at least 2)
    localparam int ID_SB_QUEUE_DEPTH = 8;

    // Field positions inside inst_info; the queue itself never looks at them
    localparam int INFO_PC_LSB        = 0;
    localparam int INFO_PC_MSB        = 31;
    localparam int INFO_IMM_LSB       = 34;
    localparam int INFO_IMM_MSB       = 65;
    localparam int INFO_FU_LSB        = 89;
    localparam int INFO_FU_MSB        = 91;
    localparam int INFO_OP_LSB        = 92;
    localparam int INFO_OP_MSB        = 103;
    localparam int INFO_EXCEPT_SW_BIT = 136;

    // Occupancy counter width for a given depth: must represent 0..depth
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : id_sb_queue_pkg
`default_nettype wire

// File: rtl/id_sb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_sb_queue_if
//  Description : Bundle between the decoder/scoreboard side (master) and the
//                decode-to-scoreboard queue (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_sb_queue_if
    import id_sb_queue_pkg::*;
#(
    parameter int WIDTH = ID_TO_SB_WD,
    parameter int DEPTH = ID_SB_QUEUE_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             in_valid;
    logic [WIDTH-1:0] in_info;
    logic             stall_o;
    logic             out_valid;
    logic [WIDTH-1:0] out_info;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    // Decoder pushes records and the scoreboard pops them
    modport master (
        output in_valid, in_info, out_ready,
        input  stall_o, out_valid, out_info, count
    );

    // Queue side
    modport slave (
        input  in_valid, in_info, out_ready,
        output stall_o, out_valid, out_info, count
    );

endinterface : id_sb_queue_if
`default_nettype wire

// File: rtl/id_sb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : id_sb_queue
//  Description : Decoupling FIFO between decode and the scoreboard. It holds
//                decoded records until the scoreboard takes them, stalls the
//                decoder while full, and empties on a pipeline flush.
//                Optional feature macro: ID_SB_QUEUE_BYPASS_EN. When it is
//                defined, a record arriving at an empty queue is presented
//                in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_sb_queue
    import id_sb_queue_pkg::*;
#(
    parameter int DEPTH = ID_SB_QUEUE_DEPTH,
    parameter int WIDTH = ID_TO_SB_WD
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    input  wire logic     flush,
    id_sb_queue_if.slave  q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             empty;
    logic             full;
    logic             bypass;
    logic             bypass_take;
    logic             push;
    logic             pop;

    // Occupancy flags from the registered pointers only
    always_comb begin
        empty = (rd_ptr_q == wr_ptr_q);
        full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                (rd_ptr_q[AW] != wr_ptr_q[AW]);
    end

    // Handshake qualification; flush overrides both push and pop
    always_comb begin
`ifdef ID_SB_QUEUE_BYPASS_EN
        bypass      = empty & q.in_valid & ~flush;
`else
        bypass      = 1'b0;
`endif
        // A bypassed record taken immediately is never written
        bypass_take = bypass & q.out_ready;
        push        = q.in_valid & ~full & ~flush & ~bypass_take;
        pop         = ~empty & q.out_ready & ~flush;
    end

    // Head presentation; stall depends on registered state only
    always_comb begin
        q.out_valid = ~empty | bypass;
        if (bypass) begin
            q.out_info = q.in_info;
        end else if (empty) begin
            q.out_info = '0;
        end else begin
            q.out_info = mem_q[rd_ptr_q[AW-1:0]];
        end
        q.stall_o = full;
        q.count   = count_q;
    end

    // Next-state pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on push; contents are not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= q.in_info;
        end
    end

endmodule : id_sb_queue
`default_nettype wire

// File: tb/tb_id_sb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_sb_queue
//  Description : Self-checking bench for id_sb_queue. It uses a vector table,
//                hand-written corner sequences, and random traffic compared
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_sb_queue;
    import id_sb_queue_pkg::*;

    localparam int W = ID_TO_SB_WD;
    localparam int D = 8;
`ifdef ID_SB_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    logic flush;

    always #5 clk = ~clk;

    id_sb_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

    id_sb_queue #(.DEPTH(D), .WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .q      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of records currently held
    logic [W-1:0] model_q [$];

    typedef struct {
        bit          iv;
        bit          rdy;
        bit          fl;
        logic [31:0] pc;
        int          ecnt;
        bit          evalid;
        bit          estall;
        logic [31:0] epc;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] pc);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
        r[INFO_PC_MSB:INFO_PC_LSB] = pc;
        return r;
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        bus.in_info   = '0;
    endtask

    // One cycle: drive, check live outputs against model, advance model at edge.
    // Called at posedge+1, returns at the following posedge+1.
    task automatic cycle(input bit iv, input bit rdy, input bit fl, input logic [W-1:0] rec);
        int       size;
        bit       exp_valid;
        bit       byp_take;
        logic [W-1:0] exp_info;
        bus.in_valid  = iv;
        bus.out_ready = rdy;
        flush         = fl;
        bus.in_info   = rec;
        @(negedge clk);
        size      = model_q.size();
        exp_valid = (size > 0) || (BYP && iv && !fl);
        exp_info  = (size > 0) ? model_q[0] : rec;
        chk("count", W'(bus.count), W'(size));
        chk("stall", W'(bus.stall_o), W'(size == D));
        chk("out_valid", W'(bus.out_valid), W'(exp_valid));
        if (exp_valid) chk("out_info", bus.out_info, exp_info);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            byp_take = BYP && (size == 0) && iv && rdy;
            if (size > 0 && rdy) void'(model_q.pop_front());
            if (iv && size < D && !byp_take) model_q.push_back(rec);
        end
        #1;
    endtask

    initial begin
        // Table: inputs applied for one edge, results observed with idle inputs
        vt[0]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00000, 1, 1'b1, 1'b0, 32'hBFC00000};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00004, 2, 1'b1, 1'b0, 32'hBFC00000};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00008, 3, 1'b1, 1'b0, 32'hBFC00000};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'hBFC0000C, 4, 1'b1, 1'b0, 32'hBFC00000};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00010, 5, 1'b1, 1'b0, 32'hBFC00000};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00014, 6, 1'b1, 1'b0, 32'hBFC00000};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00018, 7, 1'b1, 1'b0, 32'hBFC00000};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'hBFC0001C, 8, 1'b1, 1'b1, 32'hBFC00000};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00020, 8, 1'b1, 1'b1, 32'hBFC00000};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 32'hBFC00024, 7, 1'b1, 1'b0, 32'hBFC00004};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 6, 1'b1, 1'b0, 32'hBFC00008};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'hBFC00028, 0, 1'b0, 1'b0, 32'h00000000};

        resetn = 1'b0;
        idle();
        #12;
        chk("reset_count", W'(bus.count), W'(0));
        chk("reset_valid", W'(bus.out_valid), W'(0));
        chk("reset_stall", W'(bus.stall_o), W'(0));
        chk("reset_info", bus.out_info, '0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = vt[i].iv;
            bus.out_ready = vt[i].rdy;
            flush         = vt[i].fl;
            bus.in_info   = mk(vt[i].pc);
            @(posedge clk);
            #1;
            idle();
            @(negedge clk);
            chk($sformatf("tbl%0d_count", i), W'(bus.count), W'(vt[i].ecnt));
            chk($sformatf("tbl%0d_valid", i), W'(bus.out_valid), W'(vt[i].evalid));
            chk($sformatf("tbl%0d_stall", i), W'(bus.stall_o), W'(vt[i].estall));
            if (vt[i].evalid)
                chk($sformatf("tbl%0d_pc", i), W'(bus.out_info[31:0]), W'(vt[i].epc));
        end
        @(posedge clk);
        #1;

        // Fill, pop-only while full, then steady push+pop across pointer wrap
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, mk(32'hBFC00100 + 32'(i * 4)));
        cycle(1'b1, 1'b1, 1'b0, mk(32'hBFC00200));
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, mk(32'hBFC00300 + 32'(i * 4)));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Flush with five queued and simultaneous push and pop
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, mk(32'hBFC00400 + 32'(i * 4)));
        cycle(1'b1, 1'b1, 1'b1, mk(32'hBFC00500));
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Empty queue, push with ready: bypass or one-cycle latency
        cycle(1'b1, 1'b1, 1'b0, mk(32'hBFC00010));
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset with a full queue
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, mk(32'hBFC00600 + 32'(i * 4)));
        idle();
        chk("pre_reset_stall", W'(bus.stall_o), W'(1));
        #1;
        resetn = 1'b0;
        #1;
        chk("async_count", W'(bus.count), W'(0));
        chk("async_valid", W'(bus.out_valid), W'(0));
        chk("async_stall", W'(bus.stall_o), W'(0));
        model_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 24) == 0, mk($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_id_sb_queue
`default_nettype wire
